add_pipe: RTL and testbench

//  Next-generation adder for the e2e flow: a parametrised, pipelined add/sub/accumulate unit

---
 rtl/add_pipe.sv | 124 ++++++++++++
 tb/tb_add_pipe.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_pipe.sv
// add_pipe: pipelined add/sub/accumulate unit with valid/ready handshakes on both sides.
// Stage 1 computes the result and updates the accumulator at the accept cycle. Stages
// 2..STAGES only carry registered results. Empty stages fill even while the tail is
// stalled, so bubbles collapse.
module add_pipe #(
  parameter int WIDTH    = 32,
  parameter int STAGES   = 2,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             overflow
);

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_ACC  = 2'b10;

  logic             r_valid [STAGES];
  logic [WIDTH-1:0] r_data  [STAGES];
  logic             r_ovf   [STAGES];
  logic [WIDTH-1:0] r_acc;

  // w_load[k]: stage k may take a new entry this cycle. This is true when stage k is
  // empty or its occupant moves on.
  logic [STAGES-1:0] w_load;
  logic              w_accept;
  logic [WIDTH-1:0]  w_lhs;
  logic [WIDTH-1:0]  w_rhs;
  logic [WIDTH:0]    w_sum;
  logic [WIDTH-1:0]  w_res;
  logic              w_ovf;

  // Advance chain, walked from the output back to stage 1. A stage can load if it is
  // empty or if everything after it can move.
  always_comb begin
    logic w_chain;
    w_load  = '0;
    w_chain = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_chain   = !r_valid[k] || w_chain;
      w_load[k] = w_chain;
    end
  end

  assign in_ready = !reset && w_load[0];
  assign w_accept = in_valid && in_ready;

  // Stage-1 arithmetic. ACC uses the accumulator as its left operand. Saturation replaces
  // the wrapped result, but the overflow flag still reports the carry or borrow.
  always_comb begin
    w_lhs = (op == OP_ACC) ? r_acc : in0;
    w_rhs = (op == OP_ACC) ? in0 : in1;
    w_sum = {1'b0, w_lhs} + {1'b0, w_rhs};
    w_res = w_sum[WIDTH-1:0];
    w_ovf = 1'b0;
    case (op)
      OP_ADD, OP_ACC: begin
        w_ovf = w_sum[WIDTH];
        if (SATURATE && w_ovf) w_res = '1;
      end
      OP_SUB: begin
        w_ovf = (in1 > in0);
        w_res = in0 - in1;
        if (SATURATE && w_ovf) w_res = '0;
      end
      default: begin
        w_res = in0;
        w_ovf = 1'b0;
      end
    endcase
  end

  // Accumulator: ACC and LOAD commit their (post-saturation) result at the accept cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_acc <= '0;
    end else if (w_accept && op[1]) begin
      r_acc <= w_res;
    end
  end

  // Pipeline registers. Data changes only when a valid entry arrives, so the output
  // keeps its last value while idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        r_valid[k] <= 1'b0;
        r_data[k]  <= '0;
        r_ovf[k]   <= 1'b0;
      end
    end else begin
      if (w_load[0]) begin
        r_valid[0] <= w_accept;
        if (w_accept) begin
          r_data[0] <= w_res;
          r_ovf[0]  <= w_ovf;
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (w_load[k]) begin
          r_valid[k] <= r_valid[k-1];
          if (r_valid[k-1]) begin
            r_data[k] <= r_data[k-1];
            r_ovf[k]  <= r_ovf[k-1];
          end
        end
      end
    end
  end

  assign out_valid = r_valid[STAGES-1];
  assign out       = r_data[STAGES-1];
  assign overflow  = r_ovf[STAGES-1];

endmodule

// File: tb/tb_add_pipe.sv
// tb_add_pipe: checks four add_pipe variants (8-bit) against an arithmetic reference model.
// The variants are STAGES=3 wrapping, STAGES=3 saturating, STAGES=1 wrapping and
// STAGES=4 saturating.
module tb_add_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       iv   [4];
  logic       irdy [4];
  logic [7:0] ia   [4];
  logic [7:0] ib   [4];
  logic [1:0] iop  [4];
  logic       ov   [4];
  logic       ordy [4];
  logic [7:0] od   [4];
  logic       ovf  [4];

  int n_cmp = 0;
  int n_bad = 0;

  // sequence buffers for run_seq
  logic [1:0] t_op  [16];
  logic [7:0] t_a   [16];
  logic [7:0] t_b   [16];
  logic [7:0] g_out [16];
  logic       g_ovf [16];
  int         g_cnt;

  always #5 clk = ~clk;

  add_pipe #(.WIDTH(8), .STAGES(3), .SATURATE(1'b0)) u_d0 (
    .clock(clk), .reset(rst), .in_valid(iv[0]), .in_ready(irdy[0]), .in0(ia[0]), .in1(ib[0]),
    .op(iop[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out(od[0]), .overflow(ovf[0]));
  add_pipe #(.WIDTH(8), .STAGES(3), .SATURATE(1'b1)) u_d1 (
    .clock(clk), .reset(rst), .in_valid(iv[1]), .in_ready(irdy[1]), .in0(ia[1]), .in1(ib[1]),
    .op(iop[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out(od[1]), .overflow(ovf[1]));
  add_pipe #(.WIDTH(8), .STAGES(1), .SATURATE(1'b0)) u_d2 (
    .clock(clk), .reset(rst), .in_valid(iv[2]), .in_ready(irdy[2]), .in0(ia[2]), .in1(ib[2]),
    .op(iop[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out(od[2]), .overflow(ovf[2]));
  add_pipe #(.WIDTH(8), .STAGES(4), .SATURATE(1'b1)) u_d3 (
    .clock(clk), .reset(rst), .in_valid(iv[3]), .in_ready(irdy[3]), .in0(ia[3]), .in1(ib[3]),
    .op(iop[3]), .out_valid(ov[3]), .out_ready(ordy[3]), .out(od[3]), .overflow(ovf[3]));

  // Reference: plain integer arithmetic on 8-bit operands. Returns {overflow, result}.
  function automatic logic [8:0] model_op(input logic [1:0] op, input int x, input int y,
                                          input int acc, input bit sat);
    int r;
    bit c;
    case (op)
      2'd0:    begin r = x + y;   c = (r > 255); end
      2'd1:    begin r = x - y;   c = (y > x);   end
      2'd2:    begin r = acc + x; c = (r > 255); end
      default: begin r = x;       c = 1'b0;      end
    endcase
    if (c && sat) r = (op == 2'd1) ? 0 : 255;
    return {c, 8'(r)};
  endfunction

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Streams t_* entries into DUT d with out_ready high and collects results (no checks).
  task automatic run_seq(input int d, input int n);
    int sent;
    int got;
    int cyc;
    sent = 0; got = 0; cyc = 0;
    while ((sent < n || got < n) && cyc < 100) begin
      @(posedge clk); #1;
      iv[d]   = (sent < n);
      ordy[d] = 1'b1;
      if (sent < n) begin
        iop[d] = t_op[sent]; ia[d] = t_a[sent]; ib[d] = t_b[sent];
      end
      @(negedge clk);
      cyc++;
      if (ov[d] && ordy[d] && got < 16) begin
        g_out[got] = od[d]; g_ovf[got] = ovf[d]; got++;
      end
      if (iv[d] && irdy[d]) sent++;
    end
    @(posedge clk); #1;
    iv[d] = 1'b0;
    g_cnt = got;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      n_cmp += 4;
      if (ov[d] !== 1'b0)   begin n_bad++; $display("FAIL reset_out_valid d%0d: got %b want 0", d, ov[d]); end
      if (od[d] !== 8'd0)   begin n_bad++; $display("FAIL reset_out d%0d: got %0d want 0", d, od[d]); end
      if (ovf[d] !== 1'b0)  begin n_bad++; $display("FAIL reset_overflow d%0d: got %b want 0", d, ovf[d]); end
      if (irdy[d] !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready d%0d: got %b want 0", d, irdy[d]); end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (irdy[0] !== 1'b1) begin n_bad++; $display("FAIL ready_after_reset: got %b want 1", irdy[0]); end
  endtask

  // ADD 100+27: out_valid must first appear after edge N+stages-1.
  task automatic test_latency(input int d, input int stages);
    @(posedge clk); #1;
    iv[d] = 1'b1; iop[d] = 2'd0; ia[d] = 8'd100; ib[d] = 8'd27; ordy[d] = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (irdy[d] !== 1'b1) begin n_bad++; $display("FAIL lat_accept d%0d: got %b want 1", d, irdy[d]); end
    @(posedge clk); #1;
    iv[d] = 1'b0;
    for (int k = 0; k < stages; k++) begin
      @(negedge clk);
      n_cmp++;
      if (ov[d] !== (k == stages - 1)) begin
        n_bad++;
        $display("FAIL lat_valid d%0d edge+%0d: got %b want %b", d, k, ov[d], (k == stages - 1));
      end
    end
    n_cmp += 2;
    if (od[d] !== 8'd127) begin n_bad++; $display("FAIL lat_out d%0d: got %0d want 127", d, od[d]); end
    if (ovf[d] !== 1'b0)  begin n_bad++; $display("FAIL lat_ovf d%0d: got %b want 0", d, ovf[d]); end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_overflow();
    for (int d = 0; d < 2; d++) begin
      t_op[0] = 2'd0; t_a[0] = 8'd200; t_b[0] = 8'd100;
      t_op[1] = 2'd1; t_a[1] = 8'd5;   t_b[1] = 8'd9;
      run_seq(d, 2);
      n_cmp++;
      if (g_cnt !== 2) begin n_bad++; $display("FAIL ovf_count d%0d: got %0d want 2", d, g_cnt); end
      else begin
        n_cmp += 4;
        if (g_out[0] !== ((d == 1) ? 8'd255 : 8'd44))
          begin n_bad++; $display("FAIL add_ovf_out d%0d: got %0d want %0d", d, g_out[0], (d == 1) ? 255 : 44); end
        if (g_ovf[0] !== 1'b1) begin n_bad++; $display("FAIL add_ovf_flag d%0d: got %b want 1", d, g_ovf[0]); end
        if (g_out[1] !== ((d == 1) ? 8'd0 : 8'd252))
          begin n_bad++; $display("FAIL sub_ovf_out d%0d: got %0d want %0d", d, g_out[1], (d == 1) ? 0 : 252); end
        if (g_ovf[1] !== 1'b1) begin n_bad++; $display("FAIL sub_ovf_flag d%0d: got %b want 1", d, g_ovf[1]); end
      end
    end
  endtask

  task automatic test_acc();
    logic [7:0] exp_o [3];
    logic       exp_f [3];
    exp_o[0] = 8'd250; exp_o[1] = 8'd253; exp_o[2] = 8'd7;
    exp_f[0] = 1'b0;   exp_f[1] = 1'b0;   exp_f[2] = 1'b1;
    t_op[0] = 2'd3; t_a[0] = 8'd250; t_b[0] = 8'd77;
    t_op[1] = 2'd2; t_a[1] = 8'd3;   t_b[1] = 8'd200;
    t_op[2] = 2'd2; t_a[2] = 8'd10;  t_b[2] = 8'd9;
    run_seq(0, 3);
    n_cmp++;
    if (g_cnt !== 3) begin n_bad++; $display("FAIL acc_count: got %0d want 3", g_cnt); end
    else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp += 2;
        if (g_out[i] !== exp_o[i]) begin n_bad++; $display("FAIL acc_out[%0d]: got %0d want %0d", i, g_out[i], exp_o[i]); end
        if (g_ovf[i] !== exp_f[i]) begin n_bad++; $display("FAIL acc_ovf[%0d]: got %b want %b", i, g_ovf[i], exp_f[i]); end
      end
    end
    pulse_reset();
    t_op[0] = 2'd2; t_a[0] = 8'd1; t_b[0] = 8'd0;
    run_seq(0, 1);
    n_cmp++;
    if (g_cnt !== 1 || g_out[0] !== 8'd1)
      begin n_bad++; $display("FAIL acc_after_reset: got %0d (count %0d) want 1", g_out[0], g_cnt); end
  endtask

  task automatic test_reset_midflight();
    int acc_n;
    int cyc;
    acc_n = 0; cyc = 0;
    while (acc_n < 3 && cyc < 20) begin
      @(posedge clk); #1;
      iv[0] = 1'b1; iop[0] = 2'd0; ia[0] = 8'd10; ib[0] = 8'd20; ordy[0] = 1'b0;
      @(negedge clk);
      cyc++;
      if (iv[0] && irdy[0]) acc_n++;
    end
    @(posedge clk); #1;
    iv[0] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ov[0] !== 1'b1) begin n_bad++; $display("FAIL midflight_held: got %b want 1", ov[0]); end
    @(posedge clk); #1;
    rst = 1'b0;
    ordy[0] = 1'b1;
    @(negedge clk);
    n_cmp += 2;
    if (ov[0] !== 1'b0) begin n_bad++; $display("FAIL midflight_valid: got %b want 0", ov[0]); end
    if (od[0] !== 8'd0) begin n_bad++; $display("FAIL midflight_out: got %0d want 0", od[0]); end
    @(negedge clk);
    n_cmp++;
    if (ov[0] !== 1'b0) begin n_bad++; $display("FAIL post_reset_valid: got %b want 0", ov[0]); end
    t_op[0] = 2'd2; t_a[0] = 8'd5; t_b[0] = 8'd99;
    run_seq(0, 1);
    n_cmp++;
    if (g_cnt !== 1 || g_out[0] !== 8'd5)
      begin n_bad++; $display("FAIL midflight_acc: got %0d (count %0d) want 5", g_out[0], g_cnt); end
  endtask

  // 10 ADDs back-to-back on the 3-stage unit, with out_ready low for cycles 3..8.
  task automatic test_back_to_back();
    logic [8:0] q [$];
    int sent;
    int got;
    int cyc;
    bit saw_block;
    logic exp_rdy;
    sent = 0; got = 0; cyc = 0; saw_block = 1'b0;
    while (got < 10 && cyc < 60) begin
      @(posedge clk); #1;
      iv[0]   = (sent < 10);
      iop[0]  = 2'd0;
      ia[0]   = 8'(sent * 20 + 5);
      ib[0]   = 8'(sent + 1);
      ordy[0] = !(cyc >= 3 && cyc < 9);
      @(negedge clk);
      cyc++;
      exp_rdy = (q.size() < 3) || ordy[0];
      n_cmp++;
      if (irdy[0] !== exp_rdy) begin n_bad++; $display("FAIL b2b_in_ready cyc%0d: got %b want %b", cyc, irdy[0], exp_rdy); end
      if (irdy[0] === 1'b0) saw_block = 1'b1;
      if (ov[0] && ordy[0] && q.size() > 0) begin
        n_cmp++;
        if ({ovf[0], od[0]} !== q[0]) begin n_bad++; $display("FAIL b2b_result[%0d]: got %0d/%b want %0d/%b", got, od[0], ovf[0], q[0][7:0], q[0][8]); end
        void'(q.pop_front());
        got++;
      end
      if (iv[0] && irdy[0]) begin
        q.push_back(model_op(2'd0, int'(ia[0]), int'(ib[0]), 0, 1'b0));
        sent++;
      end
    end
    @(posedge clk); #1;
    iv[0] = 1'b0; ordy[0] = 1'b1;
    n_cmp += 2;
    if (got !== 10) begin n_bad++; $display("FAIL b2b_count: got %0d want 10", got); end
    if (saw_block !== 1'b1) begin n_bad++; $display("FAIL b2b_backpressure: got %b want 1", saw_block); end
  endtask

  task automatic test_random(input int d, input bit sat, input int stages, input int nops);
    logic [8:0] q [$];
    logic [8:0] e;
    logic [8:0] held;
    int acc;
    int sent;
    int got;
    int cyc;
    bit hold;
    logic exp_rdy;
    pulse_reset();
    acc = 0; sent = 0; got = 0; cyc = 0; hold = 1'b0; held = '0;
    while (got < nops && cyc < nops * 20) begin
      @(posedge clk); #1;
      iv[d]   = (sent < nops) && ($urandom_range(0, 1) == 1);
      iop[d]  = 2'($urandom_range(0, 3));
      ia[d]   = 8'($urandom);
      ib[d]   = 8'($urandom);
      ordy[d] = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      cyc++;
      if (hold) begin
        n_cmp++;
        if (ov[d] !== 1'b1 || {ovf[d], od[d]} !== held)
          begin n_bad++; $display("FAIL rnd_hold d%0d cyc%0d: got %b/%0d want 1/%0d", d, cyc, ov[d], od[d], held[7:0]); end
      end
      exp_rdy = (q.size() < stages) || ordy[d];
      n_cmp++;
      if (irdy[d] !== exp_rdy) begin n_bad++; $display("FAIL rnd_in_ready d%0d cyc%0d: got %b want %b", d, cyc, irdy[d], exp_rdy); end
      if (ov[d] === 1'b1) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++; $display("FAIL rnd_spurious d%0d cyc%0d: got out_valid 1 want 0", d, cyc);
        end else if (ordy[d]) begin
          if ({ovf[d], od[d]} !== q[0])
            begin n_bad++; $display("FAIL rnd_result d%0d #%0d: got %0d/%b want %0d/%b", d, got, od[d], ovf[d], q[0][7:0], q[0][8]); end
          void'(q.pop_front());
          got++;
        end
      end
      if (iv[d] && irdy[d]) begin
        e = model_op(iop[d], int'(ia[d]), int'(ib[d]), acc, sat);
        q.push_back(e);
        if (iop[d][1]) acc = int'(e[7:0]);
        sent++;
      end
      hold = ov[d] && !ordy[d];
      held = {ovf[d], od[d]};
    end
    @(posedge clk); #1;
    iv[d] = 1'b0; ordy[d] = 1'b1;
    n_cmp++;
    if (got !== nops) begin n_bad++; $display("FAIL rnd_count d%0d: got %0d want %0d", d, got, nops); end
    $display("random d%0d: %0d results in %0d cycles", d, got, cyc);
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 4; d++) begin
      iv[d] = 1'b0; ordy[d] = 1'b1; ia[d] = '0; ib[d] = '0; iop[d] = '0;
    end
    test_reset();
    test_latency(0, 3);
    test_latency(2, 1);
    test_latency(3, 4);
    test_overflow();
    test_acc();
    test_reset_midflight();
    test_back_to_back();
    test_random(2, 1'b0, 1, 1000);
    test_random(3, 1'b1, 4, 1000);
    test_random(0, 1'b0, 3, 500);
    test_random(1, 1'b1, 3, 500);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
